// File: rtl/sdram_port_arbiter.sv
// Arbitrates one SDRAM controller between a video burst reader, a CPU/DMA port
// and periodic refresh. All outputs come straight from flops.
module sdram_port_arbiter #(
    parameter int REFRESH_INTERVAL = 234,
    parameter int BURST_WORDS      = 4,
    parameter int CPU_MAX_WAIT     = 64
) (
    input  logic        clk30,
    input  logic        reset,
    input  logic        vid_req,
    input  logic [24:0] vid_addr,
    output logic        vid_ack,
    output logic [15:0] vid_data,
    output logic        vid_valid,
    input  logic        cpu_req,
    input  logic        cpu_wr,
    input  logic        cpu_word,
    input  logic [24:0] cpu_addr,
    input  logic [15:0] cpu_din,
    output logic [15:0] cpu_dout,
    output logic        cpu_ack,
    input  logic        disable_cpu_starve,
    output logic [24:0] sdram_addr,
    output logic        sdram_rd,
    output logic        sdram_wr,
    output logic        sdram_word,
    output logic [15:0] sdram_din,
    output logic        sdram_burst,
    output logic        sdram_refresh,
    input  logic [15:0] sdram_dout,
    input  logic        sdram_busy,
    input  logic        sdram_burstdata_valid,
    output logic        refresh_overrun
);

    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] REF_ISSUE = 3'd1;
    localparam logic [2:0] REF_WAIT  = 3'd2;
    localparam logic [2:0] VID_ISSUE = 3'd3;
    localparam logic [2:0] VID_BURST = 3'd4;
    localparam logic [2:0] CPU_ISSUE = 3'd5;
    localparam logic [2:0] CPU_WAIT  = 3'd6;

    localparam int REF_W = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
    localparam logic [REF_W-1:0] REF_LAST = REF_W'(REFRESH_INTERVAL - 1);
    localparam int BC_W = $clog2(BURST_WORDS + 1);
    localparam logic [BC_W-1:0] BURST_FULL = BC_W'(BURST_WORDS);
    localparam logic [BC_W-1:0] BURST_LAST = BC_W'(BURST_WORDS - 1);
    localparam logic [8:0] WAIT_LIMIT = (CPU_MAX_WAIT > 255) ? 9'd256 : 9'(CPU_MAX_WAIT);

    logic [2:0]       state_q,         state_d;
    logic [REF_W-1:0] ref_cnt_q,       ref_cnt_d;
    logic             ref_pending_q,   ref_pending_d;
    logic             ref_overrun_q,   ref_overrun_d;
    logic [7:0]       cpu_wait_q,      cpu_wait_d;
    logic             cpu_req_q,       cpu_req_d;
    logic             vid_req_q,       vid_req_d;
    logic             first_q,         first_d;
    logic             cpu_is_wr_q,     cpu_is_wr_d;
    logic [BC_W-1:0]  burst_cnt_q,     burst_cnt_d;
    logic [24:0]      sdram_addr_q,    sdram_addr_d;
    logic             sdram_rd_q,      sdram_rd_d;
    logic             sdram_wr_q,      sdram_wr_d;
    logic             sdram_word_q,    sdram_word_d;
    logic [15:0]      sdram_din_q,     sdram_din_d;
    logic             sdram_burst_q,   sdram_burst_d;
    logic             sdram_refresh_q, sdram_refresh_d;
    logic             vid_ack_q,       vid_ack_d;
    logic             vid_valid_q,     vid_valid_d;
    logic [15:0]      vid_data_q,      vid_data_d;
    logic             cpu_ack_q,       cpu_ack_d;
    logic [15:0]      cpu_dout_q,      cpu_dout_d;

    logic ref_wrap_s;
    logic cpu_live_s;
    logic vid_live_s;
    logic cpu_urgent_s;
    logic ref_grant_s;
    logic cpu_grant_s;
    logic vid_grant_s;
    logic cpu_active_s;
    logic words_done_s;

    // Next-state, arbitration, refresh timer and output register inputs
    always_comb begin
        state_d         = state_q;
        ref_cnt_d       = ref_cnt_q;
        ref_pending_d   = ref_pending_q;
        ref_overrun_d   = ref_overrun_q;
        cpu_wait_d      = cpu_wait_q;
        cpu_req_d       = cpu_req;
        vid_req_d       = vid_req;
        first_d         = first_q;
        cpu_is_wr_d     = cpu_is_wr_q;
        burst_cnt_d     = burst_cnt_q;
        sdram_addr_d    = sdram_addr_q;
        sdram_word_d    = sdram_word_q;
        sdram_din_d     = sdram_din_q;
        sdram_rd_d      = 1'b0;
        sdram_wr_d      = 1'b0;
        sdram_burst_d   = 1'b0;
        sdram_refresh_d = 1'b0;
        vid_ack_d       = 1'b0;
        vid_valid_d     = 1'b0;
        vid_data_d      = vid_data_q;
        cpu_ack_d       = 1'b0;
        cpu_dout_d      = cpu_dout_q;
        ref_grant_s     = 1'b0;
        cpu_grant_s     = 1'b0;
        vid_grant_s     = 1'b0;
        words_done_s    = 1'b0;

        // A request must be seen both registered and live, so one dropped before grant is lost
        cpu_live_s   = cpu_req_q & cpu_req & ~cpu_ack_q;
        vid_live_s   = vid_req_q & vid_req;
        cpu_urgent_s = disable_cpu_starve | ({1'b0, cpu_wait_q} >= WAIT_LIMIT);
        cpu_active_s = (state_q == CPU_ISSUE) | (state_q == CPU_WAIT);

        ref_wrap_s = (ref_cnt_q == REF_LAST);
        if (ref_wrap_s) begin
            ref_cnt_d = {REF_W{1'b0}};
        end else begin
            ref_cnt_d = ref_cnt_q + REF_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!sdram_busy) begin
                    if (ref_pending_q) begin
                        ref_grant_s = 1'b1;
                    end else if (cpu_live_s && cpu_urgent_s) begin
                        cpu_grant_s = 1'b1;
                    end else if (vid_live_s) begin
                        vid_grant_s = 1'b1;
                    end else if (cpu_live_s) begin
                        cpu_grant_s = 1'b1;
                    end else begin
                        ref_grant_s = 1'b0;
                    end
                end else begin
                    ref_grant_s = 1'b0;
                end

                if (ref_grant_s) begin
                    state_d         = REF_ISSUE;
                    sdram_refresh_d = 1'b1;
                end else if (cpu_grant_s) begin
                    state_d      = CPU_ISSUE;
                    sdram_addr_d = cpu_addr;
                    sdram_word_d = cpu_word;
                    sdram_din_d  = cpu_din;
                    sdram_rd_d   = ~cpu_wr;
                    sdram_wr_d   = cpu_wr;
                    cpu_is_wr_d  = cpu_wr;
                end else if (vid_grant_s) begin
                    state_d       = VID_ISSUE;
                    sdram_addr_d  = vid_addr;
                    sdram_word_d  = 1'b1;
                    sdram_rd_d    = 1'b1;
                    sdram_burst_d = 1'b1;
                    vid_ack_d     = 1'b1;
                    burst_cnt_d   = {BC_W{1'b0}};
                end else begin
                    state_d = IDLE;
                end
            end
            REF_ISSUE: begin
                state_d = REF_WAIT;
                first_d = 1'b1;
            end
            REF_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!sdram_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = REF_WAIT;
                end
            end
            CPU_ISSUE: begin
                state_d = CPU_WAIT;
                first_d = 1'b1;
            end
            CPU_WAIT: begin
                if (first_q) begin
                    first_d = 1'b0;
                end else if (!sdram_busy) begin
                    state_d   = IDLE;
                    cpu_ack_d = 1'b1;
                    if (!cpu_is_wr_q) begin
                        cpu_dout_d = sdram_dout;
                    end else begin
                        cpu_dout_d = cpu_dout_q;
                    end
                end else begin
                    state_d = CPU_WAIT;
                end
            end
            VID_ISSUE: begin
                state_d = VID_BURST;
            end
            VID_BURST: begin
                vid_data_d  = sdram_dout;
                vid_valid_d = sdram_burstdata_valid & (burst_cnt_q != BURST_FULL);
                if (vid_valid_d) begin
                    burst_cnt_d = burst_cnt_q + BC_W'(1);
                end else begin
                    burst_cnt_d = burst_cnt_q;
                end
                words_done_s = (burst_cnt_q == BURST_FULL) |
                               (sdram_burstdata_valid & (burst_cnt_q == BURST_LAST));
                if (words_done_s && !sdram_busy) begin
                    state_d = IDLE;
                end else begin
                    state_d = VID_BURST;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Refresh is only cleared when actually issued; a wrap during any other grant stays queued
        ref_overrun_d = ref_overrun_q | (ref_wrap_s & ref_pending_q);
        if (ref_grant_s) begin
            ref_pending_d = 1'b0;
        end else if (ref_wrap_s) begin
            ref_pending_d = 1'b1;
        end else begin
            ref_pending_d = ref_pending_q;
        end

        if (cpu_ack_d || !cpu_req_q) begin
            cpu_wait_d = 8'd0;
        end else if (!cpu_grant_s && !cpu_active_s && (cpu_wait_q != 8'd255)) begin
            cpu_wait_d = cpu_wait_q + 8'd1;
        end else begin
            cpu_wait_d = cpu_wait_q;
        end
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk30) begin
        if (reset) begin
            state_q         <= IDLE;
            ref_cnt_q       <= {REF_W{1'b0}};
            ref_pending_q   <= 1'b0;
            ref_overrun_q   <= 1'b0;
            cpu_wait_q      <= 8'd0;
            cpu_req_q       <= 1'b0;
            vid_req_q       <= 1'b0;
            first_q         <= 1'b0;
            cpu_is_wr_q     <= 1'b0;
            burst_cnt_q     <= {BC_W{1'b0}};
            sdram_addr_q    <= 25'd0;
            sdram_rd_q      <= 1'b0;
            sdram_wr_q      <= 1'b0;
            sdram_word_q    <= 1'b0;
            sdram_din_q     <= 16'd0;
            sdram_burst_q   <= 1'b0;
            sdram_refresh_q <= 1'b0;
            vid_ack_q       <= 1'b0;
            vid_valid_q     <= 1'b0;
            vid_data_q      <= 16'd0;
            cpu_ack_q       <= 1'b0;
            cpu_dout_q      <= 16'd0;
        end else begin
            state_q         <= state_d;
            ref_cnt_q       <= ref_cnt_d;
            ref_pending_q   <= ref_pending_d;
            ref_overrun_q   <= ref_overrun_d;
            cpu_wait_q      <= cpu_wait_d;
            cpu_req_q       <= cpu_req_d;
            vid_req_q       <= vid_req_d;
            first_q         <= first_d;
            cpu_is_wr_q     <= cpu_is_wr_d;
            burst_cnt_q     <= burst_cnt_d;
            sdram_addr_q    <= sdram_addr_d;
            sdram_rd_q      <= sdram_rd_d;
            sdram_wr_q      <= sdram_wr_d;
            sdram_word_q    <= sdram_word_d;
            sdram_din_q     <= sdram_din_d;
            sdram_burst_q   <= sdram_burst_d;
            sdram_refresh_q <= sdram_refresh_d;
            vid_ack_q       <= vid_ack_d;
            vid_valid_q     <= vid_valid_d;
            vid_data_q      <= vid_data_d;
            cpu_ack_q       <= cpu_ack_d;
            cpu_dout_q      <= cpu_dout_d;
        end
    end

    assign sdram_addr      = sdram_addr_q;
    assign sdram_rd        = sdram_rd_q;
    assign sdram_wr        = sdram_wr_q;
    assign sdram_word      = sdram_word_q;
    assign sdram_din       = sdram_din_q;
    assign sdram_burst     = sdram_burst_q;
    assign sdram_refresh   = sdram_refresh_q;
    assign vid_ack         = vid_ack_q;
    assign vid_valid       = vid_valid_q;
    assign vid_data        = vid_data_q;
    assign cpu_ack         = cpu_ack_q;
    assign cpu_dout        = cpu_dout_q;
    assign refresh_overrun = ref_overrun_q;

endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 SHALL have parameter REFRESH_INTERVAL, default 234, meaning clk30 cycles between refresh requests (7.8 us).
REQ-002 SHALL have parameter BURST_WORDS, default 4, meaning words returned per video burst read.
REQ-003 SHALL have parameter CPU_MAX_WAIT, default 64, meaning the cycle count after which a waiting CPU request outranks video.
REQ-004 SHALL have port clk30, input, 1: the only clock; all logic on its rising edge.
REQ-005 SHALL have port reset, input, 1: synchronous, active-high.
REQ-006 SHALL have ports vid_req in 1, vid_addr in 25, vid_ack out 1, vid_data out 16 and vid_valid out 1: the video fetch requester (burst read only).
REQ-007 SHALL have ports cpu_req in 1, cpu_wr in 1, cpu_word in 1, cpu_addr in 25, cpu_din in 16, cpu_dout out 16 and cpu_ack out 1: the CPU/DMA requester.
REQ-008 SHALL have port disable_cpu_starve, input, 1: when 1, CPU outranks video.
REQ-009 SHALL have ports sdram_addr out 25, sdram_rd out 1, sdram_wr out 1, sdram_word out 1, sdram_din out 16, sdram_burst out 1 and sdram_refresh out 1: the command side.
REQ-010 SHALL have ports sdram_dout in 16, sdram_busy in 1 and sdram_burstdata_valid in 1: the response side.
REQ-011 SHALL have port refresh_overrun, output, 1: sticky flag set when a refresh deadline is missed.

Function
REQ-012 SHALL implement these states: IDLE, REF_ISSUE, REF_WAIT, VID_ISSUE, VID_BURST, CPU_ISSUE, CPU_WAIT.
REQ-013 SHALL arbitrate in IDLE with this priority: refresh_pending, then CPU if (disable_cpu_starve or cpu_wait_cnt >= CPU_MAX_WAIT), then video, then CPU; the grant is taken only when sdram_busy=0.
REQ-014 SHALL, in each *_ISSUE state, drive the command strobe for exactly one cycle and hold sdram_addr, sdram_word and sdram_din stable from the issue cycle until the request completes.
REQ-015 SHALL drive the command strobes as follows: refresh drives sdram_refresh=1; video drives sdram_rd=1, sdram_burst=1 and sdram_word=1 with vid_addr; CPU drives sdram_rd=!cpu_wr, sdram_wr=cpu_wr, sdram_burst=0 and sdram_word=cpu_word.
REQ-016 SHALL ignore sdram_busy in REF_WAIT and CPU_WAIT during the first cycle after issue, and SHALL complete those states on the first later cycle with sdram_busy=0.
REQ-017 SHALL, on CPU completion, pulse cpu_ack for one cycle, latch cpu_dout from sdram_dout on reads, and return to IDLE.
REQ-018 SHALL pulse vid_ack for one cycle in the VID_ISSUE cycle.
REQ-019 SHALL, in VID_BURST, drive vid_valid=sdram_burstdata_valid and vid_data=sdram_dout, count valid words, and return to IDLE when the BURST_WORDS-th word arrives and sdram_busy=0.
REQ-020 SHALL run a refresh counter 0..REFRESH_INTERVAL-1 that wraps and sets refresh_pending on wrap.
REQ-021 SHALL clear refresh_pending on entry to REF_ISSUE.
REQ-022 SHALL set refresh_overrun (sticky until reset) if the counter wraps while refresh_pending is already 1; no second refresh is queued.
REQ-023 SHALL increment a saturating 8-bit cpu_wait_cnt each cycle cpu_req=1 without a grant, and clear it on cpu_ack.
REQ-024 SHALL register cpu_req and vid_req levels each cycle; a requester holds its request until its ack, and a request dropped before grant is discarded without an ack.
REQ-025 SHALL treat simultaneous refresh wrap and a grant cycle as follows: the grant proceeds, and refresh is taken at the next IDLE.
REQ-026 SHALL never abort an active transaction to service refresh.

Reset
REQ-027 SHALL, on reset=1, force state IDLE and clear all strobes, vid_ack, vid_valid, cpu_ack, refresh_overrun, refresh_pending, the refresh counter and cpu_wait_cnt; cpu_dout and vid_data reset to 0.
REQ-028 SHALL, on reset asserted mid-transaction, drop the transaction, generate no ack, and drive all outputs to their reset values on the following cycle.

Verification
REQ-029 SHALL verify CPU read: cpu_req=1, cpu_wr=0, addr 0x000100, SDRAM returns 0xBEEF after 3 busy cycles -> one sdram_rd pulse, one cpu_ack pulse, cpu_dout=0xBEEF.
REQ-030 SHALL verify video burst: vid_req with 4 valid words 0x1111..0x4444 -> vid_ack once, vid_valid exactly 4 cycles, data in order, then IDLE.
REQ-031 SHALL verify priority: vid_req and cpu_req asserted together with disable_cpu_starve=0 -> video first; with disable_cpu_starve=1 -> CPU first.
REQ-032 SHALL verify starvation: vid_req held continuously and cpu_req held -> CPU granted at the first IDLE after cpu_wait_cnt reaches 64.
REQ-033 SHALL verify refresh: idle bus -> sdram_refresh pulses every 234 cycles; sdram_busy held 500 cycles -> refresh_overrun=1 and it stays set.
REQ-034 SHALL verify reset: reset asserted in VID_BURST after word 2 -> next cycle all outputs 0, no vid_valid, state IDLE.
